// File: rtl/trace_capture.sv
`default_nettype none
// ============================================================================
// Module      : trace_capture
// Description : Instruction-retire trace capture. A session begins on start,
//               accepts up to MAX_RECORDS retired (pc, instr) records into a
//               first-word-fall-through FIFO, drains, and then parks in DONE.
//               Records offered while the FIFO is full (and not popping) are
//               dropped and counted.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_capture #(
  parameter int DEPTH       = 16,
  parameter int MAX_RECORDS = 51
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        cap_valid,
  input  logic [31:0] cap_pc,
  input  logic [31:0] cap_instr,
  input  logic        rec_ready,
  output logic        rec_valid,
  output logic [31:0] rec_pc,
  output logic [31:0] rec_instr,
  output logic [5:0]  rec_opcode,
  output logic [4:0]  rec_rs,
  output logic [4:0]  rec_rt,
  output logic [15:0] rec_offset,
  output logic [7:0]  rec_count,
  output logic [7:0]  drop_count,
  output logic        busy,
  output logic        done
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [AW:0] C_FULL = (AW + 1)'(DEPTH);
  localparam logic [7:0]  C_MAX  = 8'(MAX_RECORDS);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    rec_count_q, rec_count_d;
  logic [7:0]    drop_count_q, drop_count_d;
  logic [63:0]   mem_q [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_attempt;
  logic w_push_ok;
  logic w_drop;
  logic w_clear;

  // A push while full is still accepted when the head leaves in the same
  // cycle: the write lands in the slot the pop is vacating.
  assign w_empty   = (count_q == '0);
  assign w_full    = (count_q == C_FULL);
  assign w_pop     = !w_empty && rec_ready;
  assign w_attempt = (state_q == S_CAPTURE) && cap_valid;
  assign w_push_ok = w_attempt && (!w_full || w_pop);
  assign w_drop    = w_attempt && !w_push_ok;
  assign w_clear   = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a session ends on the edge that accepts its last record.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_CAPTURE;
      S_CAPTURE: if (w_push_ok && ((rec_count_q + 8'd1) == C_MAX)) state_d = S_DRAIN;
      S_DRAIN:   if (w_empty) state_d = S_DONE;
      S_DONE:    if (start) state_d = S_CAPTURE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_CAPTURE: busy = 1'b1;
      S_DRAIN:   busy = 1'b1;
      S_DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Session counters: cleared when a session starts, bumped per push outcome.
  always_comb begin
    rec_count_d  = rec_count_q;
    drop_count_d = drop_count_q;
    if (w_clear) begin
      rec_count_d  = 8'd0;
      drop_count_d = 8'd0;
    end else begin
      if (w_push_ok) rec_count_d = rec_count_q + 8'd1;
      if (w_drop && (drop_count_q != 8'hFF)) drop_count_d = drop_count_q + 8'd1;
    end
  end

  // Occupancy tracks pushes and pops independently so full and empty differ.
  always_comb begin
    count_d = count_q;
    case ({w_push_ok, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Counter, pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rec_count_q  <= 8'd0;
      drop_count_q <= 8'd0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      rec_count_q  <= rec_count_d;
      drop_count_q <= drop_count_d;
      count_q      <= count_d;
      if (w_push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage array; no reset needed since outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (w_push_ok) mem_q[wr_ptr_q] <= {cap_pc, cap_instr};
  end

  // Head record falls through combinationally; forced to zero when empty.
  always_comb begin
    rec_valid  = !w_empty;
    rec_pc     = w_empty ? 32'd0 : mem_q[rd_ptr_q][63:32];
    rec_instr  = w_empty ? 32'd0 : mem_q[rd_ptr_q][31:0];
    rec_opcode = rec_instr[31:26];
    rec_rs     = rec_instr[25:21];
    rec_rt     = rec_instr[20:16];
    rec_offset = rec_instr[15:0];
  end

  assign rec_count  = rec_count_q;
  assign drop_count = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_trace_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_trace_capture
// Description : Self-checking bench for trace_capture against a queue-based
//               reference model of the capture session.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trace_capture;

  localparam int DEPTH = 16;
  localparam int MAXR  = 51;
  localparam int M_IDLE = 0, M_CAP = 1, M_DRAIN = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        cap_valid = 1'b0;
  logic [31:0] cap_pc = '0;
  logic [31:0] cap_instr = '0;
  logic        rec_ready = 1'b0;
  logic        rec_valid;
  logic [31:0] rec_pc, rec_instr;
  logic [5:0]  rec_opcode;
  logic [4:0]  rec_rs, rec_rt;
  logic [15:0] rec_offset;
  logic [7:0]  rec_count, drop_count;
  logic        busy, done;

  trace_capture #(.DEPTH(DEPTH), .MAX_RECORDS(MAXR)) dut (
    .clk(clk), .reset(reset), .start(start), .cap_valid(cap_valid),
    .cap_pc(cap_pc), .cap_instr(cap_instr), .rec_ready(rec_ready),
    .rec_valid(rec_valid), .rec_pc(rec_pc), .rec_instr(rec_instr),
    .rec_opcode(rec_opcode), .rec_rs(rec_rs), .rec_rt(rec_rt),
    .rec_offset(rec_offset), .rec_count(rec_count), .drop_count(drop_count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  logic [63:0] m_q[$];
  int m_state = M_IDLE;
  int m_rc = 0;
  int m_dc = 0;

  logic [82:0] dut_snap;
  assign dut_snap = {rec_valid, rec_pc, rec_instr, rec_count, drop_count, busy, done};

  function automatic logic [82:0] exp_snap();
    logic [63:0] head;
    head = (m_q.size() > 0) ? m_q[0] : 64'd0;
    return {(m_q.size() > 0), head, 8'(m_rc), 8'(m_dc),
            (m_state == M_CAP || m_state == M_DRAIN), (m_state == M_DONE)};
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_state = M_IDLE;
    m_rc = 0;
    m_dc = 0;
  endfunction

  // Drive one cycle of inputs, advance the model, and settle 1ns past the edge.
  task automatic drive_cycle(input logic s, input logic v, input logic [31:0] pc,
                             input logic [31:0] ins, input logic rdy);
    int  sz;
    bit  pop, att, acc, drp;
    start = s; cap_valid = v; cap_pc = pc; cap_instr = ins; rec_ready = rdy;
    sz  = m_q.size();
    pop = (sz > 0) && rdy;
    att = (m_state == M_CAP) && v;
    acc = att && ((sz < DEPTH) || pop);
    drp = att && !acc;
    if (pop) void'(m_q.pop_front());
    if (acc) m_q.push_back({pc, ins});
    case (m_state)
      M_IDLE, M_DONE: if (s) begin m_state = M_CAP; m_rc = 0; m_dc = 0; end
      M_CAP: begin
        if (acc) m_rc++;
        if (drp && m_dc < 255) m_dc++;
        if (m_rc == MAXR) m_state = M_DRAIN;
      end
      M_DRAIN: if (sz == 0) m_state = M_DONE;
      default: m_state = M_IDLE;
    endcase
    @(posedge clk);
    #1;
    start = 1'b0; cap_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (dut_snap !== exp_snap()) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", dut_snap, exp_snap());
    end
    reset = 1'b1;
    drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    n_cmp++;
    if (dut_snap !== exp_snap()) begin
      n_fail++;
      $display("FAIL reset_idle_hold: got %h want %h", dut_snap, exp_snap());
    end
  endtask

  task automatic test_basic();
    apply_reset();
    drive_cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
    n_cmp++;
    if (rec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_valid_before: got %b want 0", rec_valid);
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b1);
      n_cmp++;
      if (dut_snap !== exp_snap()) begin
        n_fail++;
        $display("FAIL basic_push%0d: got %h want %h", i, dut_snap, exp_snap());
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      n_cmp++;
      if (dut_snap !== exp_snap()) begin
        n_fail++;
        $display("FAIL basic_drain%0d: got %h want %h", i, dut_snap, exp_snap());
      end
    end
    n_cmp++;
    if (rec_count !== 8'd3) begin
      n_fail++;
      $display("FAIL basic_count: got %0d want 3", rec_count);
    end
  endtask

  task automatic test_decode();
    apply_reset();
    drive_cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    drive_cycle(1'b0, 1'b1, 32'h100, 32'h8C2A0010, 1'b0);
    n_cmp++;
    if ({rec_opcode, rec_rs, rec_rt, rec_offset} !== {6'b100011, 5'd1, 5'd10, 16'h0010}) begin
      n_fail++;
      $display("FAIL decode_fields: got op=%b rs=%0d rt=%0d off=%h want op=100011 rs=1 rt=10 off=0010",
               rec_opcode, rec_rs, rec_rt, rec_offset);
    end
    drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    n_cmp++;
    if (dut_snap !== exp_snap()) begin
      n_fail++;
      $display("FAIL decode_pop: got %h want %h", dut_snap, exp_snap());
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    drive_cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b0, 1'b1, $urandom, $urandom, 1'b0);
      n_cmp++;
      if (dut_snap !== exp_snap()) begin
        n_fail++;
        $display("FAIL ovf_push%0d: got %h want %h", i, dut_snap, exp_snap());
      end
    end
    n_cmp++;
    if ({rec_count, drop_count} !== {8'd16, 8'd4}) begin
      n_fail++;
      $display("FAIL ovf_counts: got rc=%0d dc=%0d want rc=16 dc=4", rec_count, drop_count);
    end
    drive_cycle(1'b0, 1'b1, 32'hABCD0000, $urandom, 1'b1);
    n_cmp++;
    if ({rec_count, drop_count, rec_valid} !== {8'd17, 8'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_push_pop_full: got rc=%0d dc=%0d v=%b want rc=17 dc=4 v=1",
               rec_count, drop_count, rec_valid);
    end
    for (int i = 0; i < 17; i++) begin
      drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      n_cmp++;
      if (dut_snap !== exp_snap()) begin
        n_fail++;
        $display("FAIL ovf_drain%0d: got %h want %h", i, dut_snap, exp_snap());
      end
    end
  endtask

  task automatic test_limit();
    int guard;
    apply_reset();
    drive_cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 60; i++) begin
      drive_cycle(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b1);
      n_cmp++;
      if (dut_snap !== exp_snap()) begin
        n_fail++;
        $display("FAIL limit_cyc%0d: got %h want %h", i, dut_snap, exp_snap());
      end
    end
    guard = 0;
    while (done !== 1'b1 && guard < 40) begin
      drive_cycle(1'b0, 1'b1, $urandom, $urandom, 1'b1);
      guard++;
    end
    n_cmp++;
    if ({done, busy, rec_valid, rec_count} !== {1'b1, 1'b0, 1'b0, 8'd51}) begin
      n_fail++;
      $display("FAIL limit_done: got done=%b busy=%b v=%b rc=%0d want done=1 busy=0 v=0 rc=51",
               done, busy, rec_valid, rec_count);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive_cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b1, $urandom, $urandom, 1'b0);
    n_cmp++;
    if (rec_count !== 8'd5) begin
      n_fail++;
      $display("FAIL areset_setup: got rc=%0d want 5", rec_count);
    end
    #1 reset = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({rec_valid, rec_count, drop_count, busy, done, rec_pc, rec_instr} !== 83'd0) begin
      n_fail++;
      $display("FAIL areset_immediate: got v=%b rc=%0d dc=%0d busy=%b pc=%h want all 0",
               rec_valid, rec_count, drop_count, busy, rec_pc);
    end
    #1 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, 1'b1, $urandom, $urandom, 1'b1);
      n_cmp++;
      if (dut_snap !== exp_snap()) begin
        n_fail++;
        $display("FAIL areset_after%0d: got %h want %h", i, dut_snap, exp_snap());
      end
    end
  endtask

  task automatic test_restart();
    int guard;
    apply_reset();
    drive_cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < MAXR; i++) drive_cycle(1'b0, 1'b1, $urandom, $urandom, 1'b1);
    guard = 0;
    while (done !== 1'b1 && guard < 40) begin
      drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      guard++;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_reach_done: got done=%b want 1", done);
    end
    drive_cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
    n_cmp++;
    if ({busy, done, rec_count, drop_count} !== {1'b1, 1'b0, 8'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL restart_from_done: got busy=%b done=%b rc=%0d dc=%0d want 1 0 0 0",
               busy, done, rec_count, drop_count);
    end
    drive_cycle(1'b0, 1'b1, $urandom, $urandom, 1'b0);
    drive_cycle(1'b0, 1'b1, $urandom, $urandom, 1'b0);
    drive_cycle(1'b1, 1'b1, $urandom, $urandom, 1'b0);
    n_cmp++;
    if ({busy, rec_count} !== {1'b1, 8'd3}) begin
      n_fail++;
      $display("FAIL restart_ignored_in_capture: got busy=%b rc=%0d want busy=1 rc=3", busy, rec_count);
    end
  endtask

  task automatic test_random();
    logic s, v, r;
    int rdy_pct;
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      rdy_pct = (i < 500) ? 20 : ((i < 1000) ? 60 : 90);
      s = ($urandom_range(0, 29) == 0);
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 99) < rdy_pct);
      drive_cycle(s, v, $urandom, $urandom, r);
      n_cmp++;
      if (dut_snap !== exp_snap()) begin
        n_fail++;
        $display("FAIL random_cyc%0d: got %h want %h", i, dut_snap, exp_snap());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decode();
    test_overflow();
    test_limit();
    test_async_reset();
    test_restart();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
